// File: rtl/ff256ct_stream_ctrl.sv
// ff256ct_stream_ctrl: valid/ready intake, fixed-latency core tracking and credit-limited result FIFO.
// Define FF256CT_STREAM_CTRL_PERF_EN to add saturating pop and stall counters.
module ff256ct_stream_ctrl #(
  parameter int PIPE_LATENCY = 3,
  parameter int OUT_DEPTH    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic [63:0] core_x_in,
  input  logic [63:0] core_x_out,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [1:0]  state_o
`ifdef FF256CT_STREAM_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_vec_cnt,
  output logic [CNT_WIDTH-1:0] perf_stall_cnt
`endif
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] inflight_q, cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [PIPE_LATENCY:0] vld_q;
  logic [63:0] mem [OUT_DEPTH];
  logic acc, cap, pop;
  // Credit: every accepted vector owns a FIFO slot until it is popped.
  assign in_ready = state_q == RUN && ({1'b0, inflight_q} + {1'b0, cnt_q}) < (CW + 1)'(OUT_DEPTH);
  assign acc = in_valid & in_ready;
  // x_out settles after the core's PIPE_LATENCY edges, so it is sampled one edge later.
  assign cap = vld_q[PIPE_LATENCY];
  assign out_valid = cnt_q != '0;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem[rd_q] : '0;
  assign busy = state_q != IDLE || inflight_q != '0 || cnt_q != '0;
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && enable && !flush) state_d = RUN;
    if (state_q == RUN && (flush || !enable)) state_d = DRAIN;
    if (state_q == DRAIN && inflight_q == '0 && cnt_q == '0) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      core_x_in  <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= {vld_q[PIPE_LATENCY-1:0], acc};
      if (acc) core_x_in <= in_data;
      inflight_q <= inflight_q + CW'(acc) - CW'(cap);
      cnt_q      <= cnt_q + CW'(cap) - CW'(pop);
      wr_q       <= wr_q + AW'(cap);
      rd_q       <= rd_q + AW'(pop);
    end
  always_ff @(posedge clk)
    if (cap) mem[wr_q] <= core_x_out;
`ifdef FF256CT_STREAM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_vec_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && !(&perf_vec_cnt)) perf_vec_cnt <= perf_vec_cnt + CNT_WIDTH'(1);
      if (in_valid && !in_ready && state_q == RUN && !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + CNT_WIDTH'(1);
    end
`endif
endmodule

// File: tb/tb_ff256ct_stream_ctrl.sv
// tb_ff256ct_stream_ctrl: randomized scoreboard bench with an XOR stand-in for the transform core.
module tb_ff256ct_stream_ctrl;
  localparam int P = 3;
  localparam int D = 4;
  localparam logic [63:0] K = 64'hA5A5_A5A5_A5A5_A5A5;
  logic clk = 0, reset = 0, enable = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic [63:0] core_x_in, core_x_out, out_data;
  logic in_ready, out_valid, busy;
  logic [1:0] state_o;
  logic [63:0] pipe [P];
  logic [63:0] exp_q [$];
  logic [1:0] mstate = 2'b00;
  logic acc_f;
  int n_cmp = 0, n_bad = 0, n_pop = 0, m_stall = 0, m_vec = 0;
`ifdef FF256CT_STREAM_CTRL_PERF_EN
  logic [15:0] perf_vec_cnt, perf_stall_cnt;
`endif

  ff256ct_stream_ctrl #(.PIPE_LATENCY(P), .OUT_DEPTH(D), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_x_in(core_x_in), .core_x_out(core_x_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .state_o(state_o)
`ifdef FF256CT_STREAM_CTRL_PERF_EN
    , .perf_vec_cnt(perf_vec_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < P; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= core_x_in ^ K;
      for (int i = 1; i < P; i++) pipe[i] <= pipe[i-1];
    end
  assign core_x_out = pipe[P-1];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %h expected no result", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
        n_pop++;
        m_vec++;
      end
    end
  end

  task automatic step(logic v, logic [63:0] d, logic ordy, logic en, logic fl);
    logic rdy_m;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy; enable = en; flush = fl;
    #1;
    rdy_m = mstate == 2'b01 && exp_q.size() < D;
    chk("state", state_o, mstate);
    chk("in_ready", in_ready, rdy_m);
    chk("busy", busy, mstate != 2'b00 || exp_q.size() != 0);
    acc_f = v && rdy_m;
    if (acc_f) exp_q.push_back(d ^ K);
    if (v && !rdy_m && mstate == 2'b01) m_stall++;
    if (mstate == 2'b00 && en && !fl) mstate = 2'b01;
    else if (mstate == 2'b01 && (fl || !en)) mstate = 2'b10;
    else if (mstate == 2'b10 && exp_q.size() == 0) mstate = 2'b00;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 200 && (busy || exp_q.size() != 0); i++) step(0, '0, 1, 0, 0);
    chk(name, {busy, 31'(exp_q.size())}, '0);
  endtask

  initial begin
    int lat, na, p0;
`ifdef FF256CT_STREAM_CTRL_PERF_EN
    int s0, v0;
`endif
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_o, 0);
    chk("rst_core_x_in", core_x_in, 0);
    repeat (3) @(negedge clk);
    reset = 1;

    step(0, '0, 0, 1, 0);
    step(1, 64'h0706050403020100, 0, 1, 0);
    chk("t1_accept", acc_f, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, '0, 0, 0, 0);
      if (out_valid) begin lat = k - 1; break; end
    end
    chk("t1_latency", lat, P + 1);
    chk("t1_out_data", out_data, 64'hA2A3A0A1A6A7A4A5);
    drain("t1_busy_fall");

    p0 = n_pop;
    step(0, '0, 1, 1, 0);
    for (int i = 0; i < 16; i++)
      for (int r = 0; r < 20; r++) begin
        step(1, 64'(i), 1, 1, 0);
        if (acc_f) break;
      end
    drain("t2_drain");
    chk("t2_pops", n_pop - p0, 16);

    p0 = n_pop;
    na = 0;
    step(0, '0, 0, 1, 0);
`ifdef FF256CT_STREAM_CTRL_PERF_EN
    s0 = int'(perf_stall_cnt); v0 = int'(perf_vec_cnt);
`endif
    for (int i = 0; i < 10; i++) begin
      step(1, {$urandom, $urandom}, 0, 1, 0);
      if (acc_f) na++;
    end
    chk("t3_accepts", na, D);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    drain("t3_drain");
    chk("t3_pops", n_pop - p0, D);
`ifdef FF256CT_STREAM_CTRL_PERF_EN
    chk("t6_stall_cnt", int'(perf_stall_cnt) - s0, 6);
    chk("t6_vec_cnt", int'(perf_vec_cnt) - v0, D);
`endif

    p0 = n_pop;
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 0);
    chk("t4_state_drain", state_o, 2'b10);
    chk("t4_ready_drain", in_ready, 0);
    for (int i = 0; i < 50; i++) begin
      step(0, '0, 1, 1, 0);
      if (state_o == 2'b00) break;
    end
    chk("t4_idle", state_o, 2'b00);
    chk("t4_busy", busy, 0);
    chk("t4_pops", n_pop - p0, 3);

    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, {$urandom, $urandom}, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0);
    chk("t5_pre_valid", out_valid, 1);
    #1 reset = 0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_state", state_o, 0);
    chk("t5_core_x_in", core_x_in, 0);
    chk("t5_busy", busy, 0);
    chk("t5_out_data", out_data, 0);
    exp_q.delete();
    mstate = 2'b00; m_stall = 0; m_vec = 0;
    enable = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0, 0);
      chk("t5_no_stale", out_valid, 0);
    end

    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(9) < 6,
           $urandom_range(49) != 0, $urandom_range(99) == 0);
    drain("rand_drain");
`ifdef FF256CT_STREAM_CTRL_PERF_EN
    chk("perf_vec_total", perf_vec_cnt, m_vec);
    chk("perf_stall_total", perf_stall_cnt, m_stall);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
